// File: rtl/apb_master_bridge_mc_if.sv
// Request/response and APB bus bundle for apb_master_bridge_mc.
// master = bridge view, slave = requester/fabric view.
interface apb_master_bridge_mc_if #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_SLAVES = 4
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic                         req_valid;
  logic                         req_ready;
  logic                         req_write;
  logic [ADDR_W-1:0]            req_addr;
  logic [DATA_W-1:0]            req_wdata;
  logic [STRB_W-1:0]            req_strb;
  logic                         rsp_valid;
  logic [DATA_W-1:0]            rsp_rdata;
  logic                         rsp_err;
  logic [NUM_SLAVES-1:0]        PSEL;
  logic                         PENABLE;
  logic [ADDR_W-1:0]            PADDR;
  logic                         PWRITE;
  logic [DATA_W-1:0]            PWDATA;
  logic [STRB_W-1:0]            PSTRB;
  logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]        PREADY;
  logic [NUM_SLAVES-1:0]        PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb_master_bridge_mc.sv
// APB4 master bridge: valid/ready request -> SETUP/ACCESS transfer on one of
// NUM_SLAVES slaves, with address decode, strobes, PREADY timeout and response pulse.
module apb_master_bridge_mc #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input logic                   PCLK,
  input logic                   PRESET,
  apb_master_bridge_mc_if.master bus
);
  localparam int unsigned SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q, state_nxt;
  logic [SEL_W-1:0]      sel_q, sel_nxt, dec_sel;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic [NUM_SLAVES-1:0] psel_q, psel_nxt;
  logic                  penable_q, penable_nxt;
  logic [ADDR_W-1:0]     paddr_q, paddr_nxt;
  logic                  pwrite_q, pwrite_nxt;
  logic [DATA_W-1:0]     pwdata_q, pwdata_nxt;
  logic [STRB_W-1:0]     pstrb_q, pstrb_nxt;
  logic                  rsp_valid_q, rsp_valid_nxt;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_nxt;
  logic                  rsp_err_q, rsp_err_nxt;
  logic                  dec_ok;
  logic                  pready_sel, pslverr_sel;
  logic [DATA_W-1:0]     prdata_sel;

  assign dec_sel = bus.req_addr[ADDR_W-1 -: SEL_W];
  assign dec_ok  = 32'(dec_sel) < NUM_SLAVES;

  // Only the selected slave's response lines are observed.
  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (SEL_W'(i) == sel_q) begin
        pready_sel  = bus.PREADY[i];
        pslverr_sel = bus.PSLVERR[i];
        prdata_sel  = bus.PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt     = state_q;
    sel_nxt       = sel_q;
    cnt_nxt       = cnt_q;
    psel_nxt      = psel_q;
    penable_nxt   = penable_q;
    paddr_nxt     = paddr_q;
    pwrite_nxt    = pwrite_q;
    pwdata_nxt    = pwdata_q;
    pstrb_nxt     = pstrb_q;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata_q;
    rsp_err_nxt   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (dec_ok) begin
            sel_nxt    = dec_sel;
            psel_nxt   = NUM_SLAVES'(1) << dec_sel;
            paddr_nxt  = bus.req_addr;
            pwrite_nxt = bus.req_write;
            pwdata_nxt = bus.req_write ? bus.req_wdata : '0;
            pstrb_nxt  = bus.req_write ? bus.req_strb : '0;
            state_nxt  = SETUP;
          end else begin
            // Decode miss: answer immediately without touching the bus.
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_rdata_nxt = '0;
          end
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        if (pready_sel) begin
          state_nxt     = IDLE;
          psel_nxt      = '0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = pslverr_sel;
          rsp_rdata_nxt = (!pwrite_q && !pslverr_sel) ? prdata_sel : '0;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
          state_nxt     = IDLE;
          psel_nxt      = '0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_rdata_nxt = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      sel_q       <= sel_nxt;
      cnt_q       <= cnt_nxt;
      psel_q      <= psel_nxt;
      penable_q   <= penable_nxt;
      paddr_q     <= paddr_nxt;
      pwrite_q    <= pwrite_nxt;
      pwdata_q    <= pwdata_nxt;
      pstrb_q     <= pstrb_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
      rsp_err_q   <= rsp_err_nxt;
    end
  end

  assign bus.req_ready = (state_q == IDLE) && !PRESET;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_master_bridge_mc.sv
// Bench for apb_master_bridge_mc: directed and random transfers checked against a
// transaction-level model; extra instances cover 3 slaves and disabled timeout.
module tb_apb_master_bridge_mc;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  apb_master_bridge_mc_if #(.ADDR_W(12), .DATA_W(32), .NUM_SLAVES(4)) b0 ();
  apb_master_bridge_mc_if #(.ADDR_W(12), .DATA_W(32), .NUM_SLAVES(3)) b1 ();
  apb_master_bridge_mc_if #(.ADDR_W(12), .DATA_W(32), .NUM_SLAVES(4)) b2 ();

  apb_master_bridge_mc #(.ADDR_W(12), .DATA_W(32), .NUM_SLAVES(4), .TIMEOUT_CYC(16))
    u0 (.PCLK(clk), .PRESET(rst), .bus(b0));
  apb_master_bridge_mc #(.ADDR_W(12), .DATA_W(32), .NUM_SLAVES(3), .TIMEOUT_CYC(16))
    u1 (.PCLK(clk), .PRESET(rst), .bus(b1));
  apb_master_bridge_mc #(.ADDR_W(12), .DATA_W(32), .NUM_SLAVES(4), .TIMEOUT_CYC(0))
    u2 (.PCLK(clk), .PRESET(rst), .bus(b2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer on u0; expectations come from the transfer rules, not the FSM.
  task automatic xfer(input string tag, input logic wr, input logic [11:0] addr,
                      input logic [31:0] wd, input logic [3:0] st, input int waits,
                      input logic slverr, input logic [31:0] rd);
    int          sel;
    int          acc;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [3:0]  oh;
    sel     = int'(addr[11:10]);
    oh      = 4'b0001 << sel;
    acc     = (waits >= 16) ? 16 : waits + 1;
    exp_err = (waits >= 16) || slverr;
    exp_rd  = (!wr && !exp_err) ? rd : 32'h0;

    chk({tag, " ready_idle"}, 64'(b0.req_ready), 64'(1));
    b0.req_valid = 1'b1;
    b0.req_write = wr;
    b0.req_addr  = addr;
    b0.req_wdata = wd;
    b0.req_strb  = st;
    @(negedge clk);
    b0.req_valid = 1'b0;
    b0.PRDATA    = {$urandom(), $urandom(), $urandom(), $urandom()};
    b0.PRDATA[sel*32 +: 32] = rd;
    b0.PREADY    = 4'($urandom());
    b0.PREADY[sel]  = 1'b0;
    b0.PSLVERR   = 4'($urandom());
    b0.PSLVERR[sel] = slverr;
    chk({tag, " setup_psel"}, 64'(b0.PSEL), 64'(oh));
    chk({tag, " setup_penable"}, 64'(b0.PENABLE), 64'(0));
    chk({tag, " setup_paddr"}, 64'(b0.PADDR), 64'(addr));
    chk({tag, " setup_pwrite"}, 64'(b0.PWRITE), 64'(wr));
    chk({tag, " setup_pwdata"}, 64'(b0.PWDATA), 64'(wr ? wd : 32'h0));
    chk({tag, " setup_pstrb"}, 64'(b0.PSTRB), 64'(wr ? st : 4'h0));
    chk({tag, " setup_ready"}, 64'(b0.req_ready), 64'(0));
    chk({tag, " setup_rsp"}, 64'(b0.rsp_valid), 64'(0));
    for (int n = 0; n < acc; n++) begin
      @(negedge clk);
      chk({tag, " acc_penable"}, 64'(b0.PENABLE), 64'(1));
      chk({tag, " acc_psel"}, 64'(b0.PSEL), 64'(oh));
      chk({tag, " acc_pstrb"}, 64'(b0.PSTRB), 64'(wr ? st : 4'h0));
      chk({tag, " acc_rsp"}, 64'(b0.rsp_valid), 64'(0));
      b0.PREADY       = 4'($urandom());
      b0.PREADY[sel]  = (n >= waits);
      b0.PSLVERR      = 4'($urandom());
      b0.PSLVERR[sel] = slverr;
    end
    @(negedge clk);
    chk({tag, " rsp_valid"}, 64'(b0.rsp_valid), 64'(1));
    chk({tag, " rsp_err"}, 64'(b0.rsp_err), 64'(exp_err));
    chk({tag, " rsp_rdata"}, 64'(b0.rsp_rdata), 64'(exp_rd));
    chk({tag, " end_psel"}, 64'(b0.PSEL), 64'(0));
    chk({tag, " end_penable"}, 64'(b0.PENABLE), 64'(0));
    chk({tag, " end_ready"}, 64'(b0.req_ready), 64'(1));
    chk({tag, " hold_paddr"}, 64'(b0.PADDR), 64'(addr));
    b0.PREADY = '0;
    @(negedge clk);
    chk({tag, " rsp_pulse"}, 64'(b0.rsp_valid), 64'(0));
    chk({tag, " rsp_err_hold"}, 64'(b0.rsp_err), 64'(exp_err));
    chk({tag, " rsp_rdata_hold"}, 64'(b0.rsp_rdata), 64'(exp_rd));
  endtask

  initial begin
    int          w;
    logic        rw, se;
    logic [11:0] ad;
    logic [31:0] wd, rd;
    logic [3:0]  st;

    // Reset state, with a request offered that must be ignored.
    rst = 1'b1;
    b0.req_valid = 1'b1; b0.req_write = 1'b1; b0.req_addr = 12'h400;
    b0.req_wdata = 32'h1; b0.req_strb = 4'hF;
    b0.PRDATA = '0; b0.PREADY = '0; b0.PSLVERR = '0;
    b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0;
    b1.req_wdata = '0; b1.req_strb = '0;
    b1.PRDATA = '0; b1.PREADY = '0; b1.PSLVERR = '0;
    b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_addr = '0;
    b2.req_wdata = '0; b2.req_strb = '0;
    b2.PRDATA = '0; b2.PREADY = '0; b2.PSLVERR = '0;
    repeat (3) @(negedge clk);
    chk("rst psel", 64'(b0.PSEL), 64'(0));
    chk("rst penable", 64'(b0.PENABLE), 64'(0));
    chk("rst paddr", 64'(b0.PADDR), 64'(0));
    chk("rst pwrite", 64'(b0.PWRITE), 64'(0));
    chk("rst pwdata", 64'(b0.PWDATA), 64'(0));
    chk("rst pstrb", 64'(b0.PSTRB), 64'(0));
    chk("rst rsp_valid", 64'(b0.rsp_valid), 64'(0));
    chk("rst rsp_rdata", 64'(b0.rsp_rdata), 64'(0));
    chk("rst rsp_err", 64'(b0.rsp_err), 64'(0));
    chk("rst req_ready", 64'(b0.req_ready), 64'(0));
    b0.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst ready", 64'(b0.req_ready), 64'(1));
    chk("post_rst psel", 64'(b0.PSEL), 64'(0));

    // Directed transfers.
    xfer("wr_s1", 1'b1, 12'h400, 32'hA5A50F0F, 4'hF, 0, 1'b0, 32'h0);
    xfer("rd_s3_wait2", 1'b0, 12'hC08, 32'h0, 4'hF, 2, 1'b0, 32'hDEADBEEF);
    xfer("wr_s2_slverr", 1'b1, 12'h804, 32'h01234567, 4'h5, 0, 1'b1, 32'h0);
    xfer("rd_s0_slverr", 1'b0, 12'h00C, 32'h0, 4'h0, 1, 1'b1, 32'hCAFEF00D);
    xfer("rd_timeout", 1'b0, 12'h410, 32'h0, 4'h0, 1000, 1'b0, 32'h55AA55AA);
    xfer("wr_wait15", 1'b1, 12'hC3C, 32'h89ABCDEF, 4'h9, 15, 1'b0, 32'h0);

    // Back-to-back reads on slaves 0 then 1 with the request held valid.
    b0.PREADY = 4'hF; b0.PSLVERR = '0;
    b0.PRDATA = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    b0.req_valid = 1'b1; b0.req_write = 1'b0; b0.req_addr = 12'h010;
    @(negedge clk);
    chk("b2b setup0 psel", 64'(b0.PSEL), 64'(4'b0001));
    b0.req_addr = 12'h414;
    @(negedge clk);
    chk("b2b acc0 penable", 64'(b0.PENABLE), 64'(1));
    @(negedge clk);
    chk("b2b rsp0 valid", 64'(b0.rsp_valid), 64'(1));
    chk("b2b rsp0 rdata", 64'(b0.rsp_rdata), 64'(32'h11111111));
    chk("b2b rsp0 psel", 64'(b0.PSEL), 64'(0));
    @(negedge clk);
    b0.req_valid = 1'b0;
    chk("b2b setup1 psel", 64'(b0.PSEL), 64'(4'b0010));
    chk("b2b setup1 penable", 64'(b0.PENABLE), 64'(0));
    chk("b2b setup1 paddr", 64'(b0.PADDR), 64'(12'h414));
    @(negedge clk);
    chk("b2b acc1 penable", 64'(b0.PENABLE), 64'(1));
    @(negedge clk);
    chk("b2b rsp1 valid", 64'(b0.rsp_valid), 64'(1));
    chk("b2b rsp1 rdata", 64'(b0.rsp_rdata), 64'(32'h22222222));
    b0.PREADY = '0;
    @(negedge clk);

    // Random transfers.
    for (int k = 0; k < 40; k++) begin
      rw = 1'($urandom_range(0, 1));
      ad = 12'($urandom());
      wd = $urandom();
      st = 4'($urandom());
      w  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
      se = ($urandom_range(0, 3) == 0);
      rd = $urandom();
      xfer("rand", rw, ad, wd, st, w, se, rd);
    end

    // Three-slave instance: good read, then decode miss on sel=3.
    b1.PREADY = 3'b100; b1.PRDATA[64 +: 32] = 32'h12345678;
    b1.req_valid = 1'b1; b1.req_write = 1'b0; b1.req_addr = 12'h800;
    @(negedge clk);
    b1.req_valid = 1'b0;
    chk("ns3 setup psel", 64'(b1.PSEL), 64'(3'b100));
    repeat (2) @(negedge clk);
    chk("ns3 rd valid", 64'(b1.rsp_valid), 64'(1));
    chk("ns3 rd rdata", 64'(b1.rsp_rdata), 64'(32'h12345678));
    @(negedge clk);
    b1.req_valid = 1'b1; b1.req_addr = 12'hC00;
    @(negedge clk);
    b1.req_valid = 1'b0;
    chk("dec rsp_valid", 64'(b1.rsp_valid), 64'(1));
    chk("dec rsp_err", 64'(b1.rsp_err), 64'(1));
    chk("dec rsp_rdata", 64'(b1.rsp_rdata), 64'(0));
    chk("dec psel", 64'(b1.PSEL), 64'(0));
    chk("dec ready", 64'(b1.req_ready), 64'(1));
    @(negedge clk);
    chk("dec pulse", 64'(b1.rsp_valid), 64'(0));
    chk("dec psel2", 64'(b1.PSEL), 64'(0));

    // Timeout disabled: 100 wait cycles with no abort.
    b2.PREADY = '0;
    b2.req_valid = 1'b1; b2.req_write = 1'b1; b2.req_addr = 12'h400;
    b2.req_wdata = 32'h0BADF00D; b2.req_strb = 4'h3;
    @(negedge clk);
    b2.req_valid = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      chk("nto penable", 64'(b2.PENABLE), 64'(1));
      chk("nto psel", 64'(b2.PSEL), 64'(4'b0010));
      chk("nto rsp", 64'(b2.rsp_valid), 64'(0));
    end
    b2.PREADY = 4'b0010;
    @(negedge clk);
    chk("nto rsp_valid", 64'(b2.rsp_valid), 64'(1));
    chk("nto rsp_err", 64'(b2.rsp_err), 64'(0));
    chk("nto psel_end", 64'(b2.PSEL), 64'(0));
    b2.PREADY = '0;

    // Reset during ACCESS drops the transfer silently.
    b0.PREADY = '0;
    b0.req_valid = 1'b1; b0.req_write = 1'b0; b0.req_addr = 12'h010;
    @(negedge clk);
    b0.req_valid = 1'b0;
    @(negedge clk);
    chk("rstacc penable", 64'(b0.PENABLE), 64'(1));
    rst = 1'b1;
    b0.req_valid = 1'b1;
    @(negedge clk);
    chk("rstacc psel", 64'(b0.PSEL), 64'(0));
    chk("rstacc penable0", 64'(b0.PENABLE), 64'(0));
    chk("rstacc ready", 64'(b0.req_ready), 64'(0));
    chk("rstacc rsp", 64'(b0.rsp_valid), 64'(0));
    chk("rstacc paddr", 64'(b0.PADDR), 64'(0));
    @(negedge clk);
    chk("rstacc ready2", 64'(b0.req_ready), 64'(0));
    chk("rstacc psel2", 64'(b0.PSEL), 64'(0));
    rst = 1'b0;
    b0.req_valid = 1'b0;
    @(negedge clk);
    chk("rstacc rsp2", 64'(b0.rsp_valid), 64'(0));
    chk("rstacc ready3", 64'(b0.req_ready), 64'(1));
    chk("rstacc psel3", 64'(b0.PSEL), 64'(0));
    @(negedge clk);
    chk("rstacc rsp3", 64'(b0.rsp_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
